// File: rtl/qosc_pkg.sv
// Shared constants and state encoding for the quadrature oscillator core.
// Build option: define QOSC_AGC_EN to compile in amplitude control
// (SQ0/SQ1/ADJ states and the power latch).
package qosc_pkg;

  localparam int QOSC_WIDTH     = 8;                  // default sample width
  localparam int QOSC_FRAC      = QOSC_WIDTH - 1;     // Q1.(WIDTH-1)
  localparam int QOSC_ACC_W     = 2 * QOSC_WIDTH + 1; // sum of two products
  localparam int QOSC_AGC_SHIFT = 4;                  // AGC step is z/16

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MUL0,
    ST_MUL1,
    ST_MUL2,
    ST_MUL3,
    ST_WRITE
`ifdef QOSC_AGC_EN
    ,
    ST_SQ0,
    ST_SQ1,
    ST_ADJ
`endif
  } state_t;

endpackage

// File: rtl/qosc_round_sat.sv
// Round-half-up and saturate a product accumulator back to a WIDTH sample.
module qosc_round_sat
  import qosc_pkg::*;
#(
  parameter int WIDTH = QOSC_WIDTH,
  parameter int FRAC  = WIDTH - 1,
  parameter int ACC_W = 2 * WIDTH + 1
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [WIDTH-1:0] o_val,
  output logic                    o_clamp
);

  // One extra bit so the rounding add can never wrap.
  localparam logic signed [ACC_W:0] RND =
    {{(ACC_W + 1 - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
  localparam logic signed [ACC_W:0] VMAX =
    {{(ACC_W + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W:0] VMIN =
    {{(ACC_W + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};

  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_shr;

  // Round, scale back by FRAC, then clamp into the signed sample range.
  always_comb begin
    w_sum   = {i_acc[ACC_W-1], i_acc} + RND;
    w_shr   = w_sum >>> FRAC;
    o_clamp = 1'b0;
    o_val   = w_shr[WIDTH-1:0];
    if (w_shr > VMAX) begin
      o_val   = VMAX[WIDTH-1:0];
      o_clamp = 1'b1;
    end else if (w_shr < VMIN) begin
      o_val   = VMIN[WIDTH-1:0];
      o_clamp = 1'b1;
    end
  end

endmodule

// File: rtl/qosc_core.sv
// Quadrature oscillator: z <= z*c once per sample using one shared multiplier.
// Build option: define QOSC_AGC_EN to add energy-tracking amplitude control.
module qosc_core
  import qosc_pkg::*;
#(
  parameter int WIDTH = QOSC_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    restart,
  input  logic signed [WIDTH-1:0] init_re,
  input  logic signed [WIDTH-1:0] init_im,
  input  logic signed [WIDTH-1:0] re_coeff,
  input  logic signed [WIDTH-1:0] im_coeff,
  input  logic        [WIDTH-1:0] power,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    sat
);

  localparam int FRAC  = WIDTH - 1;
  localparam int ACC_W = 2 * WIDTH + 1;

  state_t                  r_state, w_next;
  logic signed [WIDTH-1:0] r_z_re, r_z_im, r_out_re, r_out_im;
  logic signed [WIDTH-1:0] r_cr, r_ci;
  logic signed [ACC_W-1:0] r_acc_re, r_acc_im;
  logic                    r_valid, r_sat, r_pend;

  logic signed [WIDTH-1:0]   w_mul_a, w_mul_b;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [WIDTH-1:0]   w_rs_re, w_rs_im;
  logic                      w_clamp_re, w_clamp_im;

  // Steer the single multiplier according to which product this cycle needs.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    w_mul_a = r_z_re;
    w_mul_b = r_cr;
    case (r_state)
      ST_MUL0: begin w_mul_a = r_z_re; w_mul_b = re_coeff; end // coeff not yet latched
      ST_MUL1: begin w_mul_a = r_z_im; w_mul_b = r_ci;     end
      ST_MUL2: begin w_mul_a = r_z_re; w_mul_b = r_ci;     end
      ST_MUL3: begin w_mul_a = r_z_im; w_mul_b = r_cr;     end
`ifdef QOSC_AGC_EN
      ST_SQ0:  begin w_mul_a = r_z_re; w_mul_b = r_z_re;   end
      ST_SQ1:  begin w_mul_a = r_z_im; w_mul_b = r_z_im;   end
`endif
      default: ;
    endcase
  end

  assign w_prod     = w_mul_a * w_mul_b;
  assign w_prod_ext = {{(ACC_W - 2 * WIDTH){w_prod[2*WIDTH-1]}}, w_prod};

  qosc_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_rs_re (
    .i_acc(r_acc_re), .o_val(w_rs_re), .o_clamp(w_clamp_re)
  );
  qosc_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_rs_im (
    .i_acc(r_acc_im), .o_val(w_rs_im), .o_clamp(w_clamp_im)
  );

`ifdef QOSC_AGC_EN
  localparam logic signed [WIDTH:0]   ZMAX = {2'b00, {(WIDTH - 1){1'b1}}};
  localparam logic signed [WIDTH:0]   ZMIN = {2'b11, {(WIDTH - 1){1'b0}}};
  localparam logic signed [ACC_W-1:0] EMAX = {{(ACC_W - WIDTH){1'b0}}, {WIDTH{1'b1}}};

  logic        [WIDTH-1:0] r_power;
  logic signed [ACC_W-1:0] w_esh;
  logic        [WIDTH-1:0] w_energy;
  logic signed [WIDTH-1:0] w_adj_re, w_adj_im;
  logic                    w_adj_clamp;

  // Nudge one component by +/- z/16 with saturation; MSB of result is the clamp flag.
  function automatic logic [WIDTH:0] agc_step(input logic signed [WIDTH-1:0] z,
                                              input logic up);
    logic signed [WIDTH:0] ext, delta, res;
    ext   = {z[WIDTH-1], z};
    delta = ext >>> QOSC_AGC_SHIFT;
    res   = up ? ext + delta : ext - delta;
    if (res > ZMAX)      agc_step = {1'b1, ZMAX[WIDTH-1:0]};
    else if (res < ZMIN) agc_step = {1'b1, ZMIN[WIDTH-1:0]};
    else                 agc_step = {1'b0, res[WIDTH-1:0]};
  endfunction

  // Compare measured energy against the latched target and pick the correction.
  always_comb begin
    logic [WIDTH:0] w_sr, w_si;
    w_esh       = r_acc_re >>> FRAC;
    w_energy    = (w_esh > EMAX) ? {WIDTH{1'b1}} : w_esh[WIDTH-1:0];
    w_sr        = agc_step(r_z_re, w_energy < r_power);
    w_si        = agc_step(r_z_im, w_energy < r_power);
    w_adj_re    = r_z_re;
    w_adj_im    = r_z_im;
    w_adj_clamp = 1'b0;
    if (w_energy != r_power) begin
      w_adj_re    = w_sr[WIDTH-1:0];
      w_adj_im    = w_si[WIDTH-1:0];
      w_adj_clamp = w_sr[WIDTH] | w_si[WIDTH];
    end
  end
`else
  logic w_power_unused;
  assign w_power_unused = ^power;
`endif

  // Sequencing: IDLE, four product cycles, write-back, optional AGC tail.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (enable) w_next = ST_MUL0;
      ST_MUL0:  w_next = ST_MUL1;
      ST_MUL1:  w_next = ST_MUL2;
      ST_MUL2:  w_next = ST_MUL3;
      ST_MUL3:  w_next = ST_WRITE;
`ifdef QOSC_AGC_EN
      ST_WRITE: w_next = ST_SQ0;
      ST_SQ0:   w_next = ST_SQ1;
      ST_SQ1:   w_next = ST_ADJ;
      ST_ADJ:   w_next = enable ? ST_MUL0 : ST_IDLE;
`else
      ST_WRITE: w_next = enable ? ST_MUL0 : ST_IDLE;
`endif
      default:  w_next = ST_IDLE;
    endcase
    // A state load (restart or first cycle out of reset) aborts and parks in IDLE.
    if (restart || r_pend) w_next = ST_IDLE;
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_z_re   <= '0;
      r_z_im   <= '0;
      r_out_re <= '0;
      r_out_im <= '0;
      r_cr     <= '0;
      r_ci     <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_valid  <= 1'b0;
      r_sat    <= 1'b0;
      r_pend   <= 1'b1;
`ifdef QOSC_AGC_EN
      r_power  <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      if (restart || r_pend) begin
        r_z_re <= init_re;
        r_z_im <= init_im;
        r_sat  <= 1'b0;
        r_pend <= 1'b0;
        if (restart) begin
          r_out_re <= init_re;
          r_out_im <= init_im;
        end
      end else begin
        case (r_state)
          ST_MUL0: begin
            r_cr     <= re_coeff;
            r_ci     <= im_coeff;
            r_acc_re <= w_prod_ext;
`ifdef QOSC_AGC_EN
            r_power  <= power;
`endif
          end
          ST_MUL1: r_acc_re <= r_acc_re - w_prod_ext;
          ST_MUL2: r_acc_im <= w_prod_ext;
          ST_MUL3: r_acc_im <= r_acc_im + w_prod_ext;
          ST_WRITE: begin
            r_z_re <= w_rs_re;
            r_z_im <= w_rs_im;
            r_sat  <= r_sat | w_clamp_re | w_clamp_im;
`ifndef QOSC_AGC_EN
            r_out_re <= w_rs_re;
            r_out_im <= w_rs_im;
            r_valid  <= 1'b1;
`endif
          end
`ifdef QOSC_AGC_EN
          ST_SQ0: r_acc_re <= w_prod_ext;      // accumulator reused for energy
          ST_SQ1: r_acc_re <= r_acc_re + w_prod_ext;
          ST_ADJ: begin
            r_z_re   <= w_adj_re;
            r_z_im   <= w_adj_im;
            r_out_re <= w_adj_re;
            r_out_im <= w_adj_im;
            r_sat    <= r_sat | w_adj_clamp;
            r_valid  <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_valid = r_valid;
  assign sat       = r_sat;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_qosc_core.sv
// Scoreboard bench for qosc_core: expected samples are queued as stimulus is
// applied and compared when out_valid strobes.
module tb_qosc_core;

  logic       clk = 1'b0;
  logic       reset_n, enable, restart;
  logic [7:0] init_re, init_im, re_coeff, im_coeff, power;
  logic [7:0] out_re, out_im;
  logic       out_valid, busy, sat;

  typedef struct packed {
    logic [7:0] re;
    logic [7:0] im;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;

  qosc_core #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .restart(restart),
    .init_re(init_re), .init_im(init_im),
    .re_coeff(re_coeff), .im_coeff(im_coeff), .power(power),
    .out_re(out_re), .out_im(out_im),
    .out_valid(out_valid), .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] re, input logic [7:0] im, input logic s);
    exp_t e;
    e.re  = re;
    e.im  = im;
    e.sat = s;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the next strobe, pop the scoreboard and compare.
  task automatic wait_valid(input string tag, output int cycles);
    exp_t e;
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!out_valid && cycles < 40);
    check({tag, "_seen"}, 16'(out_valid), 16'h1);
    if (out_valid) begin
      check({tag, "_sb"}, 16'(sb.size() != 0), 16'h1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_re"},  16'(out_re), 16'(e.re));
        check({tag, "_im"},  16'(out_im), 16'(e.im));
        check({tag, "_sat"}, 16'(sat),    16'(e.sat));
      end
    end
  endtask

  task automatic do_restart(input logic [7:0] re, input logic [7:0] im);
    init_re = re;
    init_im = im;
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; restart = 1'b0;
    init_re = 8'h00; init_im = 8'h00;
    re_coeff = 8'h00; im_coeff = 8'h00; power = 8'h80;
    repeat (3) step();
    check("rst_out_re", 16'(out_re),    16'h0);
    check("rst_out_im", 16'(out_im),    16'h0);
    check("rst_valid",  16'(out_valid), 16'h0);
    check("rst_busy",   16'(busy),      16'h0);
    check("rst_sat",    16'(sat),       16'h0);

    init_re = 8'h20; init_im = 8'h00;
    reset_n = 1'b1;
    step();                                   // pending load of init_*
    check("load_valid", 16'(out_valid), 16'h0);
    check("load_busy",  16'(busy),      16'h0);

`ifdef QOSC_AGC_EN
    // Amplitude control pulls |z|^2 toward the target: 0x40 -> 0x3c.
    do_restart(8'h40, 8'h00);
    re_coeff = 8'h7f; im_coeff = 8'h00; power = 8'h10;
    push_exp(8'h3c, 8'h00, 1'b0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    power  = 8'hff;                           // must not affect the latched target
    wait_valid("agc", cyc);
    check("agc_lat", 16'(cyc + 1), 16'd9);
`else
    // Single sample, enable dropped during MUL1: completes, then IDLE.
    re_coeff = 8'h7d; im_coeff = 8'h1b;
    push_exp(8'h1f, 8'h07, 1'b0);
    enable = 1'b1;
    step(); step();
    enable = 1'b0;
    wait_valid("s1", cyc);
    check("s1_lat",  16'(cyc + 2), 16'd6);
    check("s1_idle", 16'(busy),    16'h0);
    repeat (4) step();
    check("s1_hold_re", 16'(out_re),    16'h1f);
    check("s1_hold_v",  16'(out_valid), 16'h0);

    // Free-running: 5-cycle sample period, three chained rotations.
    do_restart(8'h20, 8'h00);
    push_exp(8'h1f, 8'h07, 1'b0);
    push_exp(8'h1d, 8'h0d, 1'b0);
    enable = 1'b1;
    wait_valid("run1", cyc);
    check("run1_lat", 16'(cyc), 16'd6);
    wait_valid("run2", cyc);
    check("run2_per", 16'(cyc), 16'd5);
    push_exp(8'h1a, 8'h13, 1'b0);
    enable = 1'b0;                            // third sample already in MUL0
    wait_valid("run3", cyc);
    check("run3_per", 16'(cyc), 16'd5);
    step();
    check("run3_idle", 16'(busy), 16'h0);

    // Positive clamp on the imaginary part.
    do_restart(8'h7f, 8'h7f);
    re_coeff = 8'h7f; im_coeff = 8'h7f;
    push_exp(8'h00, 8'h7f, 1'b1);
    enable = 1'b1; step(); enable = 1'b0;
    wait_valid("satp", cyc);
    repeat (2) step();
    check("sat_sticky", 16'(sat), 16'h1);

    // (-1)*(-1) overflows to +1 and clamps; restart first clears sat.
    do_restart(8'h80, 8'h00);
    check("rs_clr_sat", 16'(sat), 16'h0);
    re_coeff = 8'h80; im_coeff = 8'h00;
    push_exp(8'h7f, 8'h00, 1'b1);
    enable = 1'b1; step(); enable = 1'b0;
    wait_valid("satn", cyc);

    // Restart in MUL2 aborts the sample; computation resumes from the new init.
    re_coeff = 8'h7d; im_coeff = 8'h1b;
    enable = 1'b1;
    repeat (3) step();
    check("ab_busy_pre", 16'(busy), 16'h1);
    check("ab_sat_pre",  16'(sat),  16'h1);
    init_re = 8'h11; init_im = 8'h22;
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("ab_busy",  16'(busy),      16'h0);
    check("ab_re",    16'(out_re),    16'h11);
    check("ab_im",    16'(out_im),    16'h22);
    check("ab_sat",   16'(sat),       16'h0);
    check("ab_valid", 16'(out_valid), 16'h0);
    push_exp(8'h09, 8'h25, 1'b0);
    step();
    enable = 1'b0;
    wait_valid("ab_next", cyc);
    check("ab_resume", 16'(cyc), 16'd5);

    // Coefficient change in MUL2 only affects the following sample.
    do_restart(8'h20, 8'h00);
    re_coeff = 8'h7d; im_coeff = 8'h1b;
    push_exp(8'h1f, 8'h07, 1'b0);
    push_exp(8'hff, 8'h07, 1'b0);
    enable = 1'b1;
    repeat (3) step();
    re_coeff = 8'h00;
    wait_valid("lat1", cyc);
    enable = 1'b0;
    wait_valid("lat2", cyc);
    check("lat2_per", 16'(cyc), 16'd5);

    // Reset mid-sample discards it; the next clock reloads z from init_*.
    do_restart(8'h55, 8'h00);
    re_coeff = 8'h7d; im_coeff = 8'h1b;
    enable = 1'b1;
    repeat (2) step();
    reset_n = 1'b0; enable = 1'b0;
    step();
    check("mrst_re",    16'(out_re),    16'h0);
    check("mrst_im",    16'(out_im),    16'h0);
    check("mrst_busy",  16'(busy),      16'h0);
    check("mrst_valid", 16'(out_valid), 16'h0);
    init_re = 8'h20; init_im = 8'h00;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("mrst_quiet", 16'(out_valid), 16'h0);
    end
    push_exp(8'h1f, 8'h07, 1'b0);
    enable = 1'b1; step(); enable = 1'b0;
    wait_valid("mrst_s", cyc);
`endif

    repeat (3) step();
    check("sb_drain", 16'(sb.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
